// File: rtl/core_types_pkg.sv
// Shared core types: register tags, ROB indices, checkpoint columns and
// free-list sizing used by the rename/dispatch path.
package core_types_pkg;

    localparam int NUM_PHYS_REGS      = 64;
    localparam int NUM_ARCH_REGS      = 32;
    localparam int ROB_DEPTH          = 64;
    localparam int CHECKPOINT_COLUMNS = 4;
    localparam int FREE_LIST_DEPTH    = NUM_PHYS_REGS - NUM_ARCH_REGS;

    typedef logic [$clog2(NUM_PHYS_REGS)-1:0]      phys_reg_tag_t;
    typedef logic [$clog2(ROB_DEPTH)-1:0]          ROB_index_t;
    typedef logic [$clog2(CHECKPOINT_COLUMNS)-1:0] checkpoint_column_t;

    // Index bits plus one wrap bit, so full and empty are distinguishable.
    typedef logic [$clog2(FREE_LIST_DEPTH):0]      free_list_ptr_t;

endpackage

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags. Rename dequeues from the head,
// commit enqueues at the tail, a single-instruction revert pushes a tag back
// at the head, and per-branch head snapshots let a mispredict rewind every
// speculative allocation in one cycle.
module phys_reg_free_list
    import core_types_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    output logic               DUT_error,
    input  logic               dequeue_valid,
    output phys_reg_tag_t      dequeue_phys_reg_tag,
    output logic               free_list_empty,
    input  logic               enqueue_valid,
    input  phys_reg_tag_t      enqueue_phys_reg_tag,
    input  logic               revert_valid,
    input  phys_reg_tag_t      revert_phys_reg_tag,
    input  logic               save_checkpoint_valid,
    input  ROB_index_t         save_checkpoint_ROB_index,
    output checkpoint_column_t save_checkpoint_column,
    output logic               checkpoint_full,
    input  logic               restore_checkpoint_valid,
    input  logic               restore_checkpoint_speculate_failed,
    input  ROB_index_t         restore_checkpoint_ROB_index,
    input  checkpoint_column_t restore_checkpoint_safe_column,
    output logic               restore_checkpoint_success
);

    localparam int FREE_DEPTH = FREE_LIST_DEPTH;
    localparam int IDX_W      = $clog2(FREE_DEPTH);

    typedef struct packed {
        logic           valid;
        ROB_index_t     rob_index;
        free_list_ptr_t head;
    } checkpoint_col_t;

    phys_reg_tag_t      entries [FREE_DEPTH];
    free_list_ptr_t     head, tail;
    checkpoint_col_t    cols [CHECKPOINT_COLUMNS];
    checkpoint_column_t ptr;

    free_list_ptr_t     count, head_m1, head_n, tail_n, next_count;
    checkpoint_column_t ptr_n;
    checkpoint_col_t    sel_col;
    logic               list_full, restore_match;
    logic               enq_wr, rev_wr, rewind, save_wr, invalidate, err_n;

    assign count                  = tail - head;
    assign head_m1                = head - free_list_ptr_t'(1);
    assign list_full              = (count == free_list_ptr_t'(FREE_DEPTH));
    assign free_list_empty        = (count == '0);
    assign dequeue_phys_reg_tag   = entries[head[IDX_W-1:0]];
    assign sel_col                = cols[restore_checkpoint_safe_column];
    assign restore_match          = restore_checkpoint_valid && sel_col.valid &&
                                    (sel_col.rob_index == restore_checkpoint_ROB_index);
    assign save_checkpoint_column = ptr;
    assign checkpoint_full        = cols[ptr].valid;

    // A rewinding restore only succeeds when a revert does not preempt it;
    // a plain column release runs beside the chain and is never preempted.
    assign restore_checkpoint_success = restore_match &&
        (!restore_checkpoint_speculate_failed || !revert_valid);

    // Next-state decode: independent enqueue plus the revert > rewind > save > dequeue chain.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        head_n     = head;
        tail_n     = tail;
        ptr_n      = ptr;
        err_n      = 1'b0;
        enq_wr     = 1'b0;
        rev_wr     = 1'b0;
        rewind     = 1'b0;
        save_wr    = 1'b0;

        if (enqueue_valid) begin
            if (list_full) begin
                err_n = 1'b1;
            end else begin
                enq_wr = 1'b1;
                tail_n = tail + free_list_ptr_t'(1);
            end
            if (enqueue_phys_reg_tag == '0) err_n = 1'b1;
        end

        if (revert_valid) begin
            if (list_full) begin
                err_n = 1'b1;
            end else begin
                rev_wr = 1'b1;
                head_n = head_m1;
                if (entries[head_m1[IDX_W-1:0]] != revert_phys_reg_tag) err_n = 1'b1;
            end
        end else if (restore_checkpoint_valid && restore_checkpoint_speculate_failed) begin
            if (restore_match) begin
                rewind = 1'b1;
                head_n = sel_col.head;
                ptr_n  = restore_checkpoint_safe_column;
            end
        end else if (save_checkpoint_valid) begin
            save_wr = 1'b1;
            ptr_n   = ptr + checkpoint_column_t'(1);
            if (cols[ptr].valid) err_n = 1'b1;
        end else if (dequeue_valid) begin
            if (free_list_empty) err_n = 1'b1;
            else                 head_n = head + free_list_ptr_t'(1);
        end

        invalidate = restore_match && !restore_checkpoint_speculate_failed;

        next_count = tail_n - head_n;
        if (next_count > free_list_ptr_t'(FREE_DEPTH)) err_n = 1'b1;
    end

    // State registers: pointers, tag storage, checkpoint columns and error flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            // NOTE: the tag array is reset on purpose -- its reset contents are the initial free list.
            for (int i = 0; i < FREE_DEPTH; i++) begin
                entries[i] <= phys_reg_tag_t'(NUM_ARCH_REGS + i);
            end
            for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
                cols[c] <= '0;
            end
            head      <= '0;
            tail      <= free_list_ptr_t'(FREE_DEPTH);
            ptr       <= '0;
            DUT_error <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout; later writes below intentionally win over earlier ones.
            head      <= head_n;
            tail      <= tail_n;
            ptr       <= ptr_n;
            DUT_error <= err_n;
            if (enq_wr) entries[tail[IDX_W-1:0]] <= enqueue_phys_reg_tag;
            if (rev_wr) entries[head_m1[IDX_W-1:0]] <= revert_phys_reg_tag;
            if (rewind) begin
                for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
                    cols[c].valid <= 1'b0;
                end
            end
            if (invalidate) cols[restore_checkpoint_safe_column].valid <= 1'b0;
            // A same-cycle save to the released column keeps the new snapshot.
            if (save_wr) cols[ptr] <= '{valid: 1'b1, rob_index: save_checkpoint_ROB_index, head: head};
        end
    end

endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Supplies free physical register tags to rename. It is the producer side of the rename path that feeds the physical register map table.
- Circular FIFO of free phys reg tags:
  - dequeue on rename;
  - enqueue when commit frees an old dest;
  - un-dequeue on single-instruction revert.
- Checkpoints the FIFO head per branch, so a failed speculation rewinds all speculative allocations in one cycle.
- Lives in dispatch_unit next to the map table. Checkpoint column numbering and success semantics are identical to the map table's, so dispatch can AND the two success flags.

Parameters:
- FREE_DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS (64-32=32): FIFO entries; power of 2.
- CHECKPOINT_COLUMNS, 4 (package): number of head snapshots.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset; asynchronous, active-low.
- DUT_error  out  1  registered protocol-violation flag.
- dequeue_valid  in  1  rename consumes head tag this cycle.
- dequeue_phys_reg_tag  out  phys_reg_tag_t  current head entry (combinational).
- free_list_empty  out  1  no free tag; dispatch must stall.
- enqueue_valid  in  1  commit frees a tag.
- enqueue_phys_reg_tag  in  phys_reg_tag_t  tag to free.
- revert_valid  in  1  undo youngest rename.
- revert_phys_reg_tag  in  phys_reg_tag_t  speculated tag being returned.
- save_checkpoint_valid  in  1  snapshot head.
- save_checkpoint_ROB_index  in  ROB_index_t  branch ROB index tag.
- save_checkpoint_column  out  checkpoint_column_t  column the next save writes.
- checkpoint_full  out  1  save column still valid; dispatch must stall saves.
- restore_checkpoint_valid  in  1  branch resolved.
- restore_checkpoint_speculate_failed  in  1  1 = rewind, 0 = just free the column.
- restore_checkpoint_ROB_index  in  ROB_index_t  expected tag.
- restore_checkpoint_safe_column  in  checkpoint_column_t  column to use.
- restore_checkpoint_success  out  1  column valid and tag matched (combinational).

Behaviour:

State:
- entries[FREE_DEPTH].
- head and tail, each log2(FREE_DEPTH)+1 bits, with an MSB wrap bit.
- Checkpoint columns {valid, ROB_index, head}[CHECKPOINT_COLUMNS].
- checkpoint ptr.

Derived signals:
- count = tail-head (modular).
- empty = (count==0).
- full = (count==FREE_DEPTH).

Reset:
- entries[i] = NUM_ARCH_REGS+i.
- head = 0; tail = FREE_DEPTH (FIFO full).
- All columns invalid, with ROB_index=0 and head=0.
- ptr = 0.
- DUT_error = 0.
- Outputs at reset: dequeue_phys_reg_tag = 32, empty = 0, checkpoint_full = 0, save_checkpoint_column = 0, restore_checkpoint_success = 0.

Enqueue (independent of all other ops):
- entries[tail] = tag; tail++.
- If full: drop the write and set DUT_error.
- Enqueue of tag 0 sets DUT_error.

Priority chain (at most one per cycle), highest first:
1. revert_valid: head--; entries[head-1] = revert tag.
   - entries[head-1] != tag sets DUT_error, but the write still occurs.
   - If count==FREE_DEPTH: DUT_error, no-op.
2. restore_valid & failed: if column valid and ROB_index matches → head = column.head, all columns invalid, ptr = safe_column, success=1. Otherwise success=0 and no change.
3. save_checkpoint_valid: column[ptr] = {1, ROB_index, head}; ptr++ (wraps mod CHECKPOINT_COLUMNS).
   - If column[ptr] is already valid: DUT_error, overwrite anyway.
4. dequeue_valid: head++.
   - If empty: DUT_error, head unchanged.

Checkpoint invalidate:
- restore_valid & ~failed, evaluated in parallel with the chain.
- On tag match: column.valid = 0, success=1.
- May coincide with save/dequeue. If it targets the same column as a same-cycle save, the save wins.

Simultaneous enqueue with dequeue, revert or restore:
- Count is computed from the next head and next tail.
- A count > FREE_DEPTH after a restore sets DUT_error.

Latency:
- Reads, empty and success are same-cycle combinational.
- All state updates take effect at the next clock edge.

Reset mid-operation:
- Asynchronous return to the reset state; in-flight checkpoints are lost.

Decomposition:
- core_types_pkg: phys_reg_tag_t, ROB_index_t, checkpoint_column_t, NUM_PHYS_REGS, NUM_ARCH_REGS, CHECKPOINT_COLUMNS, and a new FREE_LIST_DEPTH plus free_list_ptr_t (log2(depth)+1 bits).
- The checkpoint column struct stays local to the module.
- No sub-module; the checkpoint array is too small to justify one.

Test Plan:
1. Reset, then 32 consecutive dequeues → tags 32..63 in order; free_list_empty=1 after the 32nd. A 33rd dequeue → DUT_error=1 next cycle.
2. From reset, enqueue tag 5 → DUT_error=1 (list full). After one dequeue (tag 32), enqueue 5 → tail entry=5, count=32, no error.
3. Dequeue 32,33; save(ROB 7) → column 0 = {valid, 7, head=2}, save_checkpoint_column becomes 1. Dequeue 34,35; restore(failed, ROB 7, col 0) → success=1, dequeue_phys_reg_tag=34, column 0 invalid.
4. Restore(failed, col 0, ROB 9) against a column saved with ROB 7 → success=0; head, pointers and columns unchanged.
5. Dequeue 32, then revert(tag 32) → head back to 0, output 32. Revert with tag 40 → DUT_error=1.
6. Four saves without restore → checkpoint_full=1; a fifth save → DUT_error=1. Restore(~failed) on column 0 alongside a dequeue → success=1, column 0 invalid, dequeue applied.
